dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the array (power of two).
REQ-002 Parameter LATENCY, default 2, wait cycles between accept and response (0..15).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  access size/sign code, RISC-V load/store funct3 encoding.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 rdata  output  32  load result, right-aligned and extended; valid only with resp_valid.
REQ-013 err  output  1  request rejected (misaligned or illegal funct3); valid only with resp_valid.

Function
REQ-014 States: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 in IDLE and RESP, 0 in WAIT.
REQ-016 Accept = req_valid & req_ready at a rising edge; we, funct3, addr and wdata SHALL be latched on that edge.
REQ-017 On accept: LATENCY=0 -> RESP; otherwise -> WAIT with counter loaded to LATENCY-1.
REQ-018 WAIT: counter decrements each cycle; at counter 0 next state is RESP.
REQ-019 resp_valid SHALL be 1 exactly in RESP, i.e. LATENCY+1 cycles after the accept edge.
REQ-020 RESP with accept -> same transitions as REQ-017 (back-to-back, one response per cycle at LATENCY=0); RESP without accept -> IDLE.
REQ-021 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo array size).
REQ-022 Legal funct3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 100/101 legal for loads only.
REQ-023 err SHALL be set for illegal funct3, half access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-024 On err: array unchanged, rdata = 0.
REQ-025 Store commit SHALL occur on the edge entering RESP, writing only addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2 and +1; word: all four).
REQ-026 Load data SHALL be sampled from the array on the edge entering RESP, so a load accepted after a store to the same address returns the stored value.
REQ-027 Load extension: signed byte/half sign-extend from bit 7/15; unsigned byte/half zero-extend; word unchanged.
REQ-028 Stores SHALL produce resp_valid with rdata = 0 and err per REQ-023.
REQ-029 Stable outputs: rdata and err SHALL be 0 whenever resp_valid = 0.

Reset
REQ-030 reset low SHALL force state IDLE, counter 0, resp_valid 0, rdata 0, err 0, req_ready 1 immediately (asynchronously).
REQ-031 A request in WAIT when reset asserts SHALL be discarded; a pending store SHALL NOT commit.
REQ-032 Array contents are not initialised by reset.

Structure
REQ-033 Package dmem_pkg SHALL hold funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
REQ-034 Sub-module dmem_lane_align SHALL implement combinational byte-lane steering for stores and extraction/extension for loads; the FSM, counter and array stay in dmem_responder.

Verification
REQ-035 LATENCY=2: SW addr 0x10 wdata 0xDEADBEEF accepted at cycle 0 -> resp_valid only at cycle 3, err 0; then LW 0x10 -> rdata 0xDEADBEEF.
REQ-036 After REQ-035: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-037 SB addr 0x11 wdata 0x00000055 -> LW 0x10 returns 0xDEAD55EF; SH 0x12 wdata 0x1234 -> LW 0x10 returns 0x123455EF.
REQ-038 LW 0x11, LH 0x13, funct3 011, SBU (we=1, funct3 100) -> each err 1, rdata 0, array word 0x10 unchanged.
REQ-039 LATENCY=0, req_valid held high with 4 loads -> resp_valid high 4 consecutive cycles, req_ready never low; DEPTH_WORDS=1024 LW 0x1010 returns word 0x10.
REQ-040 SW 0x20 0xCAFEF00D then reset low during WAIT -> resp_valid never asserts, req_ready 1 at once; later LW 0x20 does not return 0xCAFEF00D (prior value preserved).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// FSM state type and the request legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 1 when the access must be rejected: unknown size code, unsigned store,
  // or an address not aligned to the access size.
  function automatic logic access_err(input logic i_we, input logic [2:0] i_f3,
                                      input logic [1:0] i_addr_lo);
    logic e;
    e = 1'b0;
    case (i_f3)
      F3_B:    e = 1'b0;
      F3_H:    e = i_addr_lo[0];
      F3_W:    e = |i_addr_lo;
      F3_BU:   e = i_we;
      F3_HU:   e = i_we | i_addr_lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
// Purely combinational; legality is decided by the caller.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wword,
  output logic [3:0]  o_be,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_wword = {4{i_wdata[7:0]}};
    o_be    = '0;
    o_rdata = '0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        o_wword = {2{i_wdata[15:0]}};
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_rdata = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      2'b10: begin
        o_wword = i_wdata;
        o_be    = '1;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data memory answering one load/store at a time after a
// fixed number of wait cycles; misaligned or illegal accesses are flagged.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_we;
  logic [2:0]    w_f3;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic          w_err;
  logic          w_commit;
  logic [31:0]   w_wword;
  logic [3:0]    w_be;
  logic [31:0]   w_ld;
  logic          w_unused;

  assign req_ready  = (r_state != ST_WAIT);
  assign w_accept   = req_valid & req_ready;
  assign resp_valid = (r_state == ST_RESP);
  assign rdata      = r_rdata;
  assign err        = r_err;

  // With zero latency the edge that accepts is also the edge entering RESP,
  // so the request is serviced straight from the ports instead of the latch.
  assign w_enter_resp = (LATENCY == 0) ? w_accept
                                       : ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_we    = (LATENCY == 0) ? we     : r_we;
  assign w_f3    = (LATENCY == 0) ? funct3 : r_f3;
  assign w_addr  = (LATENCY == 0) ? addr   : r_addr;
  assign w_wdata = (LATENCY == 0) ? wdata  : r_wdata;

  assign w_idx    = w_addr[AW+1:2];
  assign w_rword  = r_mem[w_idx];
  assign w_err    = access_err(w_we, w_f3, w_addr[1:0]);
  assign w_unused = ^w_addr[31:AW+2];

  // Reset gating keeps a request arriving during reset from writing the array.
  assign w_commit = w_enter_resp & w_we & ~w_err & reset;

  dmem_lane_align u_align (
    .i_funct3  (w_f3),
    .i_addr_lo (w_addr[1:0]),
    .i_wdata   (w_wdata),
    .i_rword   (w_rword),
    .o_wword   (w_wword),
    .o_be      (w_be),
    .o_rdata   (w_ld)
  );

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err | w_we) ? '0 : w_ld;
      end
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            r_we    <= we;
            r_f3    <= funct3;
            r_addr  <= addr;
            r_wdata <= wdata;
            if (LATENCY == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= LAT_LOAD;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance checked every
// cycle against a byte-level memory model with response due-cycle queues.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
    logic        known;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn  [2];
  logic        rv    [2];
  logic        we_i  [2];
  logic [2:0]  f3_i  [2];
  logic [31:0] ad_i  [2];
  logic [31:0] wd_i  [2];
  logic        rdy_o [2];
  logic        vld_o [2];
  logic [31:0] rd_o  [2];
  logic        err_o [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q [2][$];
  logic [7:0] mm [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rstn[0]), .req_valid(rv[0]), .req_ready(rdy_o[0]),
    .we(we_i[0]), .funct3(f3_i[0]), .addr(ad_i[0]), .wdata(wd_i[0]),
    .resp_valid(vld_o[0]), .rdata(rd_o[0]), .err(err_o[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(rstn[1]), .req_valid(rv[1]), .req_ready(rdy_o[1]),
    .we(we_i[1]), .funct3(f3_i[1]), .addr(ad_i[1]), .wdata(wd_i[1]),
    .resp_valid(vld_o[1]), .rdata(rd_o[1]), .err(err_o[1]));

  function automatic int lat(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Byte-addressed memory model: sizes, alignment, little-endian assembly, extension.
  function automatic void model(input int s, input bit w, input bit [2:0] f,
                                input bit [31:0] a, input bit [31:0] d,
                                output bit [31:0] rd, output bit er, output bit kn);
    int sz;
    int base;
    bit [31:0] v;
    rd = '0; er = 1'b0; kn = 1'b1;
    case (f)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    if (sz == 0 || (w && f[2]) || (a % sz) != 0) begin
      er = 1'b1;
      return;
    end
    base = s * (1 << 24) + int'(a % (1024 * 4));
    if (w) begin
      for (int b = 0; b < sz; b++) mm[base + b] = d[8*b +: 8];
      return;
    end
    v = '0;
    for (int b = 0; b < sz; b++) begin
      if (!mm.exists(base + b)) kn = 1'b0;
      else v = v | (32'(mm[base + b]) << (8 * b));
    end
    if (sz < 4 && !f[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    rd = v;
  endfunction

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      logic ev, ee, kn, re;
      logic [31:0] erd;
      exp_t f;
      ev = 1'b0; ee = 1'b0; kn = 1'b1; re = 1'b1; erd = '0;
      if (q[s].size() != 0) begin
        f = q[s][0];
        if (cyc >= f.due - lat(s) && cyc < f.due) re = 1'b0;
        if (cyc == f.due) begin
          ev = 1'b1; ee = f.er; erd = f.rd; kn = f.known;
          void'(q[s].pop_front());
        end
      end
      check($sformatf("dut%0d resp_valid", s), 32'(vld_o[s]), 32'(ev));
      check($sformatf("dut%0d req_ready", s), 32'(rdy_o[s]), 32'(re));
      check($sformatf("dut%0d err", s), 32'(err_o[s]), 32'(ee));
      if (kn) check($sformatf("dut%0d rdata", s), rd_o[s], erd);
    end
  end

  task automatic issue(input int s, input bit w, input bit [2:0] f, input bit [31:0] a,
                       input bit [31:0] d, input bit [31:0] lit_rd, input bit lit_er,
                       input bit commit);
    int tries;
    exp_t e;
    bit [31:0] mr;
    bit me, mk;
    @(posedge clk); #2;
    rv[s] = 1'b1; we_i[s] = w; f3_i[s] = f; ad_i[s] = a; wd_i[s] = d;
    tries = 0;
    while (!rdy_o[s] && tries < 40) begin
      @(posedge clk); #2;
      tries++;
    end
    if (!rdy_o[s]) begin
      check($sformatf("dut%0d accept_timeout", s), 32'(rdy_o[s]), 32'd1);
      return;
    end
    if (commit) begin
      model(s, w, f, a, d, mr, me, mk);
      if (mk) check($sformatf("dut%0d pin rdata @%h", s, a), mr, lit_rd);
      check($sformatf("dut%0d pin err @%h", s, a), 32'(me), 32'(lit_er));
      e.due = cyc + 1 + lat(s); e.rd = mr; e.er = me; e.known = mk;
      q[s].push_back(e);
    end
  endtask

  task automatic idle(input int s);
    @(posedge clk); #2;
    rv[s] = 1'b0;
  endtask

  task automatic drain(input int s);
    int t;
    idle(s);
    t = 0;
    while (q[s].size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (q[s].size() != 0) begin
      check($sformatf("dut%0d drain_timeout", s), 32'(q[s].size()), 32'd0);
      q[s].delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rstn[s] = 1'b0; rv[s] = 1'b0; we_i[s] = 1'b0;
      f3_i[s] = '0; ad_i[s] = '0; wd_i[s] = '0;
    end
    repeat (3) @(posedge clk);
    #3;
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // LATENCY=2: word store, reads of every size, partial stores.
    issue(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
    issue(0, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
    issue(0, 0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 0, 1);
    issue(0, 0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 0, 1);
    issue(0, 0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 0, 1);
    issue(0, 0, F3_HU, 32'h10, 32'h0,        32'h0000BEEF, 0, 1);
    issue(0, 1, F3_B,  32'h11, 32'h00000055, 32'h0,        0, 1);
    issue(0, 0, F3_W,  32'h10, 32'h0,        32'hDEAD55EF, 0, 1);
    issue(0, 1, F3_H,  32'h12, 32'h00001234, 32'h0,        0, 1);
    issue(0, 0, F3_W,  32'h10, 32'h0,        32'h123455EF, 0, 1);
    // Rejected accesses leave the array alone.
    issue(0, 0, F3_W,  32'h11, 32'h0,        32'h0,        1, 1);
    issue(0, 0, F3_H,  32'h13, 32'h0,        32'h0,        1, 1);
    issue(0, 0, 3'b011, 32'h10, 32'h0,       32'h0,        1, 1);
    issue(0, 1, F3_BU, 32'h10, 32'h000000AA, 32'h0,        1, 1);
    issue(0, 1, F3_H,  32'h11, 32'h0000FFFF, 32'h0,        1, 1);
    issue(0, 0, F3_W,  32'h10, 32'h0,        32'h123455EF, 0, 1);
    issue(0, 1, F3_W,  32'h20, 32'h11112222, 32'h0,        0, 1);
    issue(0, 0, F3_W,  32'h20, 32'h0,        32'h11112222, 0, 1);
    drain(0);

    // Store interrupted by reset while waiting must be dropped.
    issue(0, 1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
    @(posedge clk); #2;
    rv[0] = 1'b0;
    check("dut0 busy before reset", 32'(rdy_o[0]), 32'd0);
    #1;
    rstn[0] = 1'b0;
    #1;
    check("dut0 ready on reset", 32'(rdy_o[0]), 32'd1);
    check("dut0 resp_valid on reset", 32'(vld_o[0]), 32'd0);
    check("dut0 rdata on reset", rd_o[0], 32'd0);
    repeat (4) @(posedge clk);
    #3;
    rstn[0] = 1'b1;
    issue(0, 0, F3_W, 32'h20, 32'h0, 32'h11112222, 0, 1);
    drain(0);

    // LATENCY=0: back-to-back requests with valid held high, address wrap.
    issue(1, 1, F3_W,  32'h10,   32'hA5A50F0F, 32'h0,        0, 1);
    issue(1, 0, F3_W,  32'h10,   32'h0,        32'hA5A50F0F, 0, 1);
    issue(1, 0, F3_W,  32'h1010, 32'h0,        32'hA5A50F0F, 0, 1);
    issue(1, 0, F3_BU, 32'h11,   32'h0,        32'h0000000F, 0, 1);
    issue(1, 0, F3_H,  32'h12,   32'h0,        32'hFFFFA5A5, 0, 1);
    issue(1, 0, F3_W,  32'h13,   32'h0,        32'h0,        1, 1);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
